// File: rtl/ntt_ctrl_if.sv
// Handshake and RAM/butterfly control bundle between the NTT front end and ntt_ctrl.
// master: the side that issues set/inv and consumes the sequencer outputs.
// slave:  the ntt_ctrl sequencer itself.
interface ntt_ctrl_if;
  logic       set;
  logic       inv;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [7:0] rd_addr_a;
  logic [7:0] rd_addr_b;
  logic [6:0] zeta_idx;
  logic [1:0] bf_mode;
  logic       wr_en;
  logic [7:0] wr_addr_a;
  logic [7:0] wr_addr_b;

  modport master (
    output set, inv,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx, bf_mode,
    input  wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input  set, inv,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx, bf_mode,
    output wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_ctrl.sv
// Sequencer for the in-place Kyber NTT (N=256, q=3329). Issues one radix-2
// butterfly per cycle: RAM read addresses, zeta ROM index and butterfly mode,
// plus the matching write addresses LAT cycles later.
// Optional feature macro: NTT_INV_EN (inverse NTT with final scale-by-f pass).
// Without it the inv port is accepted but ignored and only the forward
// transform is sequenced.
module ntt_ctrl #(
  parameter int LAT = 4
) (
  input logic      clk,
  input logic      reset,
  ntt_ctrl_if.slave bus
);

`ifdef NTT_INV_EN
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, SCALE, DRAIN2, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FIN} state_t;
`endif

  localparam logic [3:0] DLAST = 4'(LAT - 1);

  state_t     state, state_n;
  logic [2:0] layer, layer_n;
  logic [6:0] b, b_n;
  logic [3:0] dcnt, dcnt_n;
  logic       inv_sel;

`ifdef NTT_INV_EN
  logic inv_r, inv_n;
  assign inv_sel = inv_r;
`else
  logic unused_inv;
  assign unused_inv = bus.inv;
  assign inv_sel    = 1'b0;
`endif

  // butterfly address/zeta arithmetic
  logic [2:0] s_w;
  logic [7:0] len_w, b8, grp_w, off_w, bf_a_w, bf_b_w;
  logic [6:0] zeta_w;

  // combinational outputs of the current state
  logic       rd_en_c, busy_c, done_c;
  logic [7:0] addr_a_c, addr_b_c;
  logic [6:0] zeta_c;
  logic [1:0] mode_c;

  // write-side delay line, LAT stages deep
  logic       vld_p    [LAT];
  logic [7:0] addr_a_p [LAT];
  logic [7:0] addr_b_p [LAT];

  // control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      layer <= 3'd0;
      b     <= 7'd0;
      dcnt  <= 4'd0;
`ifdef NTT_INV_EN
      inv_r <= 1'b0;
`endif
    end else begin
      state <= state_n;
      layer <= layer_n;
      b     <= b_n;
      dcnt  <= dcnt_n;
`ifdef NTT_INV_EN
      inv_r <= inv_n;
`endif
    end
  end

  // next-state logic: RUN a layer, DRAIN the pipe, then next layer / SCALE / FIN
  always_comb begin
    state_n = state;
    layer_n = layer;
    b_n     = b;
    dcnt_n  = dcnt;
`ifdef NTT_INV_EN
    inv_n   = inv_r;
`endif
    case (state)
      IDLE: begin
        if (bus.set) begin
          state_n = RUN;
          layer_n = 3'd0;
          b_n     = 7'd0;
`ifdef NTT_INV_EN
          inv_n   = bus.inv;
`endif
        end
      end
      RUN: begin
        b_n = b + 7'd1;
        if (b == 7'd127) begin
          state_n = DRAIN;
          dcnt_n  = 4'd0;
        end
      end
      DRAIN: begin
        if (dcnt == DLAST) begin
          b_n    = 7'd0;
          dcnt_n = 4'd0;
          if (layer != 3'd6) begin
            state_n = RUN;
            layer_n = layer + 3'd1;
          end else begin
            layer_n = 3'd0;
            state_n = FIN;
`ifdef NTT_INV_EN
            if (inv_r) state_n = SCALE;
`endif
          end
        end else begin
          dcnt_n = dcnt + 4'd1;
        end
      end
`ifdef NTT_INV_EN
      SCALE: begin
        b_n = b + 7'd1;
        if (b == 7'd127) begin
          state_n = DRAIN2;
          dcnt_n  = 4'd0;
        end
      end
      DRAIN2: begin
        if (dcnt == DLAST) begin
          state_n = FIN;
          dcnt_n  = 4'd0;
        end else begin
          dcnt_n = dcnt + 4'd1;
        end
      end
`endif
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // butterfly index math: len = 2^s, group/offset split of b, zeta for the group
  always_comb begin
    s_w    = inv_sel ? (3'd1 + layer) : (3'd7 - layer);
    len_w  = 8'd1 << s_w;
    b8     = {1'b0, b};
    grp_w  = b8 >> s_w;
    off_w  = b8 & (len_w - 8'd1);
    bf_a_w = (grp_w << ({1'b0, s_w} + 4'd1)) | off_w;
    bf_b_w = bf_a_w + len_w;
    if (inv_sel)
      zeta_w = 7'((8'd128 >> layer) - 8'd1) - grp_w[6:0];
    else
      zeta_w = (7'd1 << layer) + grp_w[6:0];
  end

  // per-state outputs; addresses are held at zero whenever no read is issued
  always_comb begin
    rd_en_c  = 1'b0;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    addr_a_c = 8'd0;
    addr_b_c = 8'd0;
    zeta_c   = 7'd0;
    mode_c   = 2'b00;
    case (state)
      RUN: begin
        rd_en_c  = 1'b1;
        busy_c   = 1'b1;
        addr_a_c = bf_a_w;
        addr_b_c = bf_b_w;
        zeta_c   = zeta_w;
        mode_c   = inv_sel ? 2'b01 : 2'b00;
      end
      DRAIN: busy_c = 1'b1;
`ifdef NTT_INV_EN
      SCALE: begin
        rd_en_c  = 1'b1;
        busy_c   = 1'b1;
        addr_a_c = {1'b0, b};
        addr_b_c = {1'b1, b};
        mode_c   = 2'b10;
      end
      DRAIN2: busy_c = 1'b1;
`endif
      FIN:     done_c = 1'b1;
      default: ;
    endcase
  end

  // write-enable delay line; cleared on reset so aborted writes are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= rd_en_c;
      for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // write-address delay line travelling alongside vld_p
  always_ff @(posedge clk) begin
    addr_a_p[0] <= addr_a_c;
    addr_b_p[0] <= addr_b_c;
    for (int i = 1; i < LAT; i++) begin
      addr_a_p[i] <= addr_a_p[i-1];
      addr_b_p[i] <= addr_b_p[i-1];
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.rd_en     = rd_en_c;
  assign bus.rd_addr_a = addr_a_c;
  assign bus.rd_addr_b = addr_b_c;
  assign bus.zeta_idx  = zeta_c;
  assign bus.bf_mode   = mode_c;
  assign bus.wr_en     = vld_p[LAT-1];
  assign bus.wr_addr_a = vld_p[LAT-1] ? addr_a_p[LAT-1] : 8'd0;
  assign bus.wr_addr_b = vld_p[LAT-1] ? addr_b_p[LAT-1] : 8'd0;

endmodule
